tcp_option_decoder: RTL and testbench



---
 rtl/tcp_option_decoder.sv | 242 ++++++++++++++++++++++++
 tb/tb_tcp_option_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tcp_option_decoder.sv
// Receive-side TCP option parser: byte-serial walk of the option area, extracting MSS, window scale, SACK-permitted, SACK blocks and timestamps.
// Latency: a word's bytes are consumed on the 4 edges after it is accepted; done is high in the cycle after the edge that consumes the last byte.
// Backpressure: data_ready is raised only when the word buffer holds at most one byte; data_valid low stalls parsing once the buffer drains.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, opt_words      begin a new option area of opt_words 32-bit words (0..10)
//   data_in/_valid/_ready option word handshake, byte 0 in [31:24]
//   option_av             bit k set when option kind k (k<=8) parsed validly
//   mss, scale_wnd        kind 2 / kind 3 values
//   sack_nbr, sack_n0..3  SACK block count and {left, right} edges
//   time_stp              kind 8 {TSval, TSecr}
//   done, error           end-of-area pulse; malformed area flag held until next start
module tcp_option_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  opt_words,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [8:0]  option_av,
    output logic [15:0] mss,
    output logic [7:0]  scale_wnd,
    output logic [2:0]  sack_nbr,
    output logic [63:0] sack_n0,
    output logic [63:0] sack_n1,
    output logic [63:0] sack_n2,
    output logic [63:0] sack_n3,
    output logic [63:0] time_stp,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, KIND, LEN, BODY, SKIP} state_t;

    state_t      state, state_next;
    logic [31:0] word_buf;
    logic [2:0]  byte_cnt;
    logic [3:0]  words_left;
    logic [7:0]  kind_q;
    logic [7:0]  body_cnt;
    logic [2:0]  sack_cnt;    // (L-2)/8 of the SACK option in flight
    logic [2:0]  sack_sub;    // byte position within the current SACK block
    logic [1:0]  sack_idx;
    logic [55:0] acc_q;
    logic [63:0] sack_q [4];

    logic [7:0]  cur_byte;
    logic [63:0] acc_next;
    logic        busy, byte_fire, word_fire, area_end, start_fire;
    logic [6:0]  bytes_rem;
    logic [7:0]  len_body;
    logic        kind_len_bad, len_bad;

    // control decoded by the next-state process
    logic        av_set, err_set, kind_ld, len_ld, body_step, body_last, done_set;
    logic [3:0]  av_idx;

    assign busy       = (state != IDLE);
    assign cur_byte   = word_buf[31:24];
    assign acc_next   = {acc_q, cur_byte};
    assign data_ready = busy && (words_left != 4'd0) && (byte_cnt <= 3'd1);
    assign word_fire  = data_valid && data_ready;
    assign byte_fire  = busy && (byte_cnt != 3'd0);
    assign start_fire = start && (state == IDLE);
    // the byte being consumed is the final byte of the whole area
    assign area_end   = byte_fire && (words_left == 4'd0) && (byte_cnt == 3'd1);

    // bytes left in the area after the current one; a word being accepted
    // this same cycle is still counted in words_left
    assign bytes_rem  = {1'b0, words_left, 2'b00} + {4'd0, byte_cnt} - 7'd1;
    assign len_body   = cur_byte - 8'd2;

    always_comb begin
        kind_len_bad = 1'b0;
        case (kind_q)
            8'd2:    kind_len_bad = (cur_byte != 8'd4);
            8'd3:    kind_len_bad = (cur_byte != 8'd3);
            8'd4:    kind_len_bad = (cur_byte != 8'd2);
            8'd5:    kind_len_bad = !((cur_byte == 8'd10) || (cur_byte == 8'd18) ||
                                      (cur_byte == 8'd26) || (cur_byte == 8'd34));
            8'd8:    kind_len_bad = (cur_byte != 8'd10);
            default: kind_len_bad = 1'b0;
        endcase
    end

    assign len_bad = (cur_byte < 8'd2) || (len_body > {1'b0, bytes_rem}) || kind_len_bad;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        av_set     = 1'b0;
        av_idx     = kind_q[3:0];
        err_set    = 1'b0;
        kind_ld    = 1'b0;
        len_ld     = 1'b0;
        body_step  = 1'b0;
        body_last  = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    done_set   = (opt_words == 4'd0);
                    state_next = (opt_words == 4'd0) ? IDLE : KIND;
                end
            end
            KIND: begin
                if (byte_fire) begin
                    if (cur_byte == 8'd0) begin
                        av_set     = 1'b1;
                        av_idx     = 4'd0;
                        state_next = SKIP;
                    end else if (cur_byte == 8'd1) begin
                        av_set = 1'b1;
                        av_idx = 4'd1;
                    end else begin
                        kind_ld    = 1'b1;
                        state_next = LEN;
                        // a kind byte with no room left for its length byte
                        err_set    = area_end;
                    end
                end
            end
            LEN: begin
                if (byte_fire) begin
                    if (len_bad) begin
                        err_set    = 1'b1;
                        state_next = SKIP;
                    end else if (cur_byte == 8'd2) begin
                        av_set     = (kind_q <= 8'd8);
                        state_next = KIND;
                    end else begin
                        len_ld     = 1'b1;
                        state_next = BODY;
                    end
                end
            end
            BODY: begin
                if (byte_fire) begin
                    body_step = 1'b1;
                    if (body_cnt == 8'd1) begin
                        body_last  = 1'b1;
                        av_set     = (kind_q <= 8'd8);
                        state_next = KIND;
                    end else begin
                        err_set = area_end;
                    end
                end
            end
            SKIP:    state_next = SKIP;
            default: state_next = IDLE;
        endcase
        if (area_end) begin
            done_set   = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_buf   <= '0;
            byte_cnt   <= '0;
            words_left <= '0;
            kind_q     <= '0;
            body_cnt   <= '0;
            sack_cnt   <= '0;
            sack_sub   <= '0;
            sack_idx   <= '0;
            acc_q      <= '0;
            option_av  <= '0;
            mss        <= '0;
            scale_wnd  <= '0;
            sack_nbr   <= '0;
            for (int i = 0; i < 4; i++) sack_q[i] <= '0;
            time_stp   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= done_set;
            if (start_fire) begin
                words_left <= opt_words;
                byte_cnt   <= '0;
                option_av  <= '0;
                mss        <= '0;
                scale_wnd  <= '0;
                sack_nbr   <= '0;
                for (int i = 0; i < 4; i++) sack_q[i] <= '0;
                time_stp   <= '0;
                error      <= 1'b0;
            end else begin
                if (word_fire) begin
                    word_buf   <= data_in;
                    byte_cnt   <= 3'd4;
                    words_left <= words_left - 4'd1;
                end else if (byte_fire) begin
                    word_buf   <= {word_buf[23:0], 8'h00};
                    byte_cnt   <= byte_cnt - 3'd1;
                end
                if (kind_ld) kind_q <= cur_byte;
                if (len_ld) begin
                    body_cnt <= len_body;
                    sack_cnt <= len_body[5:3];
                    sack_sub <= '0;
                    sack_idx <= '0;
                end
                if (body_step) begin
                    acc_q    <= acc_next[55:0];
                    body_cnt <= body_cnt - 8'd1;
                    if (kind_q == 8'd5) begin
                        sack_sub <= sack_sub + 3'd1;
                        if (sack_sub == 3'd7) begin
                            sack_q[sack_idx] <= acc_next;
                            sack_idx         <= sack_idx + 2'd1;
                        end
                    end
                end
                if (body_last) begin
                    case (kind_q)
                        8'd2:    mss       <= acc_next[15:0];
                        8'd3:    scale_wnd <= acc_next[7:0];
                        8'd5:    sack_nbr  <= sack_cnt;
                        8'd8:    time_stp  <= acc_next;
                        default: ;
                    endcase
                end
                if (av_set)  option_av <= option_av | (9'd1 << av_idx);
                if (err_set) error     <= 1'b1;
            end
        end
    end

    assign sack_n0 = sack_q[0];
    assign sack_n1 = sack_q[1];
    assign sack_n2 = sack_q[2];
    assign sack_n3 = sack_q[3];

endmodule

// File: tb/tb_tcp_option_decoder.sv
module tb_tcp_option_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  opt_words;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [8:0]  option_av;
    logic [15:0] mss;
    logic [7:0]  scale_wnd;
    logic [2:0]  sack_nbr;
    logic [63:0] sack_n0, sack_n1, sack_n2, sack_n3;
    logic [63:0] time_stp;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcp_option_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opt_words  (opt_words),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .option_av  (option_av),
        .mss        (mss),
        .scale_wnd  (scale_wnd),
        .sack_nbr   (sack_nbr),
        .sack_n0    (sack_n0),
        .sack_n1    (sack_n1),
        .sack_n2    (sack_n2),
        .sack_n3    (sack_n3),
        .time_stp   (time_stp),
        .done       (done),
        .error      (error)
    );

    // Pulse start, then feed words at negedges. lat = clocks from the first
    // accepting edge to the edge that raised done (or the start edge when n=0).
    // stall: hold data_valid low for 5 cycles after each accept.
    // stop_after>0: return 3 cycles after accepting that many words.
    task automatic run_area(input int n, input logic [31:0] w [10], input bit stall,
                            input int stop_after, output int lat);
        int idx, hold, first, last_acc, cyc;
        bit fin;
        idx = 0; hold = 0; first = -1; last_acc = -100; lat = -1; cyc = 0; fin = 0;
        @(negedge clk);
        start     = 1'b1;
        opt_words = 4'(n);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 400) begin
            if (done) begin
                lat = cyc - first - 1;
                fin = 1;
            end else if (stop_after > 0 && idx == stop_after && cyc == last_acc + 3) begin
                fin = 1;
            end else begin
                if (hold > 0) begin
                    data_valid = 1'b0;
                    hold--;
                end else if (idx < n) begin
                    data_valid = 1'b1;
                    data_in    = w[idx];
                end else begin
                    data_valid = 1'b0;
                end
                if (data_valid && data_ready) begin
                    if (idx == 0) first = cyc;
                    last_acc = cyc;
                    idx++;
                    hold = stall ? 5 : 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; opt_words = '0; data_in = '0; data_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (option_av !== 9'h000) begin failures++; $display("FAIL reset_option_av got=%h exp=000", option_av); end
        checks++; if (mss !== 16'h0) begin failures++; $display("FAIL reset_mss got=%h exp=0", mss); end
        checks++; if (time_stp !== 64'h0) begin failures++; $display("FAIL reset_time_stp got=%h exp=0", time_stp); end
        checks++; if (sack_nbr !== 3'd0) begin failures++; $display("FAIL reset_sack_nbr got=%0d exp=0", sack_nbr); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
    endtask

    task automatic test_basic(input bit stall, input string tag);
        logic [31:0] w [10];
        int lat, exp_lat;
        w = '{32'h020405B4, 32'h03030701, 32'h04020101, 32'h080A1122, 32'h33445566,
              32'h77880101, 32'h0, 32'h0, 32'h0, 32'h0};
        // each of the 5 gaps between words loses 2 clocks when stalled
        exp_lat = stall ? 34 : 24;
        run_area(6, w, stall, 0, lat);
        checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, exp_lat); end
        checks++; if (option_av !== 9'h11E) begin failures++; $display("FAIL %s_option_av got=%h exp=11e", tag, option_av); end
        checks++; if (mss !== 16'h05B4) begin failures++; $display("FAIL %s_mss got=%h exp=05b4", tag, mss); end
        checks++; if (scale_wnd !== 8'd7) begin failures++; $display("FAIL %s_scale_wnd got=%0d exp=7", tag, scale_wnd); end
        checks++; if (time_stp !== 64'h1122334455667788) begin failures++; $display("FAIL %s_time_stp got=%h exp=1122334455667788", tag, time_stp); end
        checks++; if (sack_nbr !== 3'd0) begin failures++; $display("FAIL %s_sack_nbr got=%0d exp=0", tag, sack_nbr); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL %s_error got=%b exp=0", tag, error); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b exp=0", tag, done); end
    endtask

    task automatic test_zero_words();
        logic [31:0] w [10];
        int lat;
        w = '{default: 32'h0};
        run_area(0, w, 1'b0, 0, lat);
        checks++; if (lat !== 0) begin failures++; $display("FAIL zero_latency got=%0d exp=0", lat); end
        checks++; if (option_av !== 9'h000) begin failures++; $display("FAIL zero_option_av got=%h exp=000", option_av); end
        checks++; if (mss !== 16'h0) begin failures++; $display("FAIL zero_mss got=%h exp=0", mss); end
        checks++; if (time_stp !== 64'h0) begin failures++; $display("FAIL zero_time_stp got=%h exp=0", time_stp); end
        checks++; if (scale_wnd !== 8'd0) begin failures++; $display("FAIL zero_scale_wnd got=%0d exp=0", scale_wnd); end
    endtask

    task automatic test_sack();
        logic [31:0] w [10];
        int lat;
        w = '{32'h01010512, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_area(5, w, 1'b0, 0, lat);
        checks++; if (lat !== 20) begin failures++; $display("FAIL sack_latency got=%0d exp=20", lat); end
        checks++; if (sack_nbr !== 3'd2) begin failures++; $display("FAIL sack_nbr got=%0d exp=2", sack_nbr); end
        checks++; if (sack_n0 !== 64'h0000000100000002) begin failures++; $display("FAIL sack_n0 got=%h exp=0000000100000002", sack_n0); end
        checks++; if (sack_n1 !== 64'h0000000300000004) begin failures++; $display("FAIL sack_n1 got=%h exp=0000000300000004", sack_n1); end
        checks++; if (sack_n2 !== 64'h0) begin failures++; $display("FAIL sack_n2 got=%h exp=0", sack_n2); end
        checks++; if (option_av !== 9'h022) begin failures++; $display("FAIL sack_option_av got=%h exp=022", option_av); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL sack_error got=%b exp=0", error); end
    endtask

    task automatic test_bad_len();
        logic [31:0] w [10];
        int lat;
        w = '{32'h02050000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_area(1, w, 1'b0, 0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL badlen_latency got=%0d exp=4", lat); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL badlen_error got=%b exp=1", error); end
        checks++; if (option_av !== 9'h000) begin failures++; $display("FAIL badlen_option_av got=%h exp=000", option_av); end
        checks++; if (mss !== 16'h0) begin failures++; $display("FAIL badlen_mss got=%h exp=0", mss); end
    endtask

    task automatic test_overrun_and_eol();
        logic [31:0] w [10];
        int lat;
        w = '{32'h080A1122, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_area(1, w, 1'b0, 0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL overrun_latency got=%0d exp=4", lat); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL overrun_error got=%b exp=1", error); end
        checks++; if (option_av !== 9'h000) begin failures++; $display("FAIL overrun_option_av got=%h exp=000", option_av); end
        w[0] = 32'h00FFFFFF;
        run_area(1, w, 1'b0, 0, lat);
        checks++; if (option_av !== 9'h001) begin failures++; $display("FAIL eol_option_av got=%h exp=001", option_av); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL eol_error got=%b exp=0", error); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL eol_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_reset_mid_body();
        logic [31:0] w [10];
        int lat;
        w = '{32'h020405B4, 32'h03030701, 32'h04020101, 32'h080A1122, 32'h33445566,
              32'h77880101, 32'h0, 32'h0, 32'h0, 32'h0};
        // stop once the timestamp kind and length bytes are consumed
        run_area(6, w, 1'b0, 4, lat);
        checks++; if (mss !== 16'h05B4) begin failures++; $display("FAIL midreset_pre_mss got=%h exp=05b4", mss); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (option_av !== 9'h000) begin failures++; $display("FAIL midreset_option_av got=%h exp=000", option_av); end
        checks++; if (mss !== 16'h0) begin failures++; $display("FAIL midreset_mss got=%h exp=0", mss); end
        checks++; if (scale_wnd !== 8'd0) begin failures++; $display("FAIL midreset_scale_wnd got=%0d exp=0", scale_wnd); end
        checks++; if (time_stp !== 64'h0) begin failures++; $display("FAIL midreset_time_stp got=%h exp=0", time_stp); end
        checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL midreset_data_ready got=%b exp=0", data_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        test_basic(1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_zero_words();
        test_sack();
        test_bad_len();
        test_overrun_and_eol();
        test_basic(1'b1, "stall");
        test_reset_mid_body();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
